alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Executes the same 4-bit aluc operation set at any power-of-two WIDTH with 1-cycle latency.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with a valid/ready input handshake.
- Sits between the register-file read stage and write-back of the CPU datapath.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; equals (state==IDLE)
- md_en  in  1  0 = ALU op, 1 = mul/div op
- aluc  in  4  opcode
- a  in  WIDTH  operand A; a[SHW-1:0] is the shift amount
- b  in  WIDTH  operand B
- out_valid  out  1  one-cycle result pulse
- r  out  WIDTH  result, quotient, or product low half
- r_hi  out  WIDTH  product high half or remainder; 0 for ALU ops
- zero, carry, negative, overflow  out  1 each  flags
- div_by_zero  out  1  divisor was 0

Behaviour:
- Reset: state=IDLE; out_valid, r, r_hi and all flags are 0; in_ready=1 in the cycle after rst deasserts.
- Accept: in_valid & in_ready at a rising edge.
- Outputs are registered and hold until the next result; out_valid pulses for exactly one cycle.
- There is no output backpressure.

ALU ops (md_en=0), latency 1, back-to-back accepts every cycle:
- Opcodes: 0000 ADDU, 0001 SUBU, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 100x LUI ({b[WIDTH/2-1:0], zeros}), 1010 SLTU, 1011 SLT, 1100 SRA, 1101 SRL, 111x SLL.
- Any flag not listed for an op is driven to 0; flags never hold stale values.
- ADDU: carry = carry-out of bit WIDTH-1.
- SUBU: carry = borrow (a<b unsigned).
- ADD/SUB: overflow = signed overflow; r wraps.
- All ops except SLT/SLTU: zero = (r==0), negative = r[WIDTH-1].
- SLT: r = signed a<b, zero = (a==b), negative = signed a<b.
- SLTU: r = unsigned a<b, zero = (a==b), carry = unsigned a<b.
- Shifts: shamt = a[SHW-1:0], shifting b. carry = last bit shifted out, or 0 when shamt==0.

Mul/div ops (md_en=1), aluc 0000 MULTU, 0001 MULT, 0010 DIVU, 0011 DIV:
- Other codes: illegal; latency 1, r=r_hi=0, all flags 0.
- FSM: IDLE -> MUL or DIV on accept, iterate WIDTH cycles, -> IDLE.
- Results register on the final iteration edge; out_valid asserts the following cycle.
- Total latency WIDTH+1 cycles from accept; in_ready=0 for WIDTH cycles.
- Signed ops: convert operands to magnitudes, run shift-add multiply or restoring divide, negate the product/quotient if the signs differ, and give the remainder the sign of a.
- MULT/MULTU: {r_hi,r} = full 2*WIDTH product; zero = (product==0); negative = r_hi[WIDTH-1] for MULT only.
- DIV/DIVU: r = quotient, r_hi = remainder; zero = (quotient==0); negative = r[WIDTH-1] for DIV only.
- b==0 is detected at accept, latency 1: r = all ones, r_hi = a, div_by_zero=1.
- DIV with most-negative a and b = -1: r = most-negative, r_hi = 0, overflow=1.
- rst during MUL/DIV aborts the operation: no out_valid and no result update for it.
- in_valid while busy is ignored, because in_ready=0.

Decomposition:
- Package alu_mdu_pkg: aluc opcode localparams (ALU and mul/div), FSM state enum, flag bundle typedef.
- Sub-module md_iter: iterative shift-add/restoring-divide datapath with start/done. Top holds the combinational ALU, the FSM, sign handling and output registers.

Test Plan (WIDTH=32):
- ADDU a=FFFFFFFF, b=00000001 -> next cycle r=0, zero=1, carry=1, overflow=0, out_valid=1 for one cycle.
- ADD a=7FFFFFFF, b=1, then SUB a=80000000, b=1 on consecutive cycles:
  - ADD -> r=80000000, overflow=1, negative=1.
  - SUB -> r=7FFFFFFF, overflow=1.
  - Both accepted back-to-back, two consecutive out_valid pulses.
- SRA a=4, b=80000018 -> r=F8000001, carry=1. SLL a=0, b=1 -> r=1, carry=0.
- MULT a=FFFFFFFE, b=3 -> after 33 cycles r_hi=FFFFFFFF, r=FFFFFFFA, negative=1; in_ready=0 for 32 cycles; an in_valid pulse mid-operation is ignored.
- DIV cases:
  - a=FFFFFFF9, b=2 -> r=FFFFFFFD, r_hi=FFFFFFFF.
  - DIVU b=0 -> r=FFFFFFFF, r_hi=a, div_by_zero=1 after 1 cycle.
  - DIV a=80000000, b=FFFFFFFF -> r=80000000, overflow=1.
- DIVU started, rst asserted at cycle 10 -> next cycle in_ready=1, out_valid stays 0 for 40 cycles, r=0.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared opcode encodings, FSM states and flag bundle for the alu_mdu execute block.
package alu_mdu_pkg;

  localparam logic [3:0] ALU_ADDU    = 4'b0000;
  localparam logic [3:0] ALU_SUBU    = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0101;
  localparam logic [3:0] ALU_XOR     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b0111;
  localparam logic [3:0] ALU_LUI     = 4'b1000;
  localparam logic [3:0] ALU_LUI_ALT = 4'b1001;
  localparam logic [3:0] ALU_SLTU    = 4'b1010;
  localparam logic [3:0] ALU_SLT     = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1100;
  localparam logic [3:0] ALU_SRL     = 4'b1101;
  localparam logic [3:0] ALU_SLL     = 4'b1110;
  localparam logic [3:0] ALU_SLL_ALT = 4'b1111;

  localparam logic [3:0] MD_MULTU = 4'b0000;
  localparam logic [3:0] MD_MULT  = 4'b0001;
  localparam logic [3:0] MD_DIVU  = 4'b0010;
  localparam logic [3:0] MD_DIV   = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
    logic div_by_zero;
  } flags_t;

endpackage

// File: rtl/alu_mdu_md_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             div_mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   add_sum, trial;

  // hi:lo is the product accumulator (multiplier shifts out of lo) or remainder:quotient.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    trial   = {hi, lo[WIDTH-1]} - {1'b0, m};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Results are the post-step values so the caller can register them on the final edge.
  assign done   = busy && (cnt == CW'(WIDTH - 1));
  assign res_lo = lo_nxt;
  assign res_hi = hi_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      hi       <= '0;
      lo       <= opa;
      m        <= opb;
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with an iterative multiply/divide unit behind a valid/ready input handshake.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             md_en,
  input  logic [3:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t state, state_nxt;
  flags_t flg;

  logic accept;
  logic md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign accept = in_valid & in_ready;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] alu_r;
  flags_t           alu_f;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   shamt, shr_idx, sll_idx;
  logic             unsigned_lt, signed_lt;

  assign add_w       = {1'b0, a} + {1'b0, b};
  assign sub_w       = {1'b0, a} - {1'b0, b};
  assign unsigned_lt = sub_w[WIDTH];
  assign signed_lt   = $signed(a) < $signed(b);
  assign shamt       = a[SHW-1:0];
  assign shr_idx     = shamt - SHW'(1);
  // WIDTH is a power of two, so -shamt wraps to WIDTH-shamt: the last bit shifted out left.
  assign sll_idx     = -shamt;

  always_comb begin
    alu_r = '0;
    alu_f = '0;
    case (aluc)
      ALU_ADDU: begin
        alu_r       = add_w[WIDTH-1:0];
        alu_f.carry = add_w[WIDTH];
      end
      ALU_SUBU: begin
        alu_r       = sub_w[WIDTH-1:0];
        alu_f.carry = sub_w[WIDTH];
      end
      ALU_ADD: begin
        alu_r          = add_w[WIDTH-1:0];
        alu_f.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_r          = sub_w[WIDTH-1:0];
        alu_f.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: alu_r = a & b;
      ALU_OR:  alu_r = a | b;
      ALU_XOR: alu_r = a ^ b;
      ALU_NOR: alu_r = ~(a | b);
      ALU_LUI, ALU_LUI_ALT: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLTU: begin
        alu_r       = WIDTH'(unsigned_lt);
        alu_f.carry = unsigned_lt;
      end
      ALU_SLT: begin
        alu_r          = WIDTH'(signed_lt);
        alu_f.negative = signed_lt;
      end
      ALU_SRA: begin
        alu_r       = $signed(b) >>> shamt;
        alu_f.carry = (shamt != '0) & b[shr_idx];
      end
      ALU_SRL: begin
        alu_r       = b >> shamt;
        alu_f.carry = (shamt != '0) & b[shr_idx];
      end
      ALU_SLL, ALU_SLL_ALT: begin
        alu_r       = b << shamt;
        alu_f.carry = (shamt != '0) & b[sll_idx];
      end
      default: alu_r = '0;
    endcase
    if (aluc == ALU_SLT || aluc == ALU_SLTU) begin
      alu_f.zero = (a == b);
    end else begin
      alu_f.zero     = (alu_r == '0);
      alu_f.negative = alu_r[WIDTH-1];
    end
  end

  // ---------------- mul/div decode and sign handling ----------------
  logic             md_is_mul, md_is_div, md_signed, b_zero, a_neg, b_neg, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign md_is_mul = md_en & ((aluc == MD_MULTU) | (aluc == MD_MULT));
  assign md_is_div = md_en & ((aluc == MD_DIVU) | (aluc == MD_DIV));
  assign md_signed = (aluc == MD_MULT) | (aluc == MD_DIV);
  assign b_zero    = (b == '0);
  assign a_neg     = md_signed & a[WIDTH-1];
  assign b_neg     = md_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign div_ovf   = (aluc == MD_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  logic pend_neg, pend_rem_neg, pend_signed, pend_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_neg     <= 1'b0;
      pend_rem_neg <= 1'b0;
      pend_signed  <= 1'b0;
      pend_ovf     <= 1'b0;
    end else if (md_start) begin
      pend_neg     <= a_neg ^ b_neg;
      pend_rem_neg <= a_neg;
      pend_signed  <= md_signed;
      pend_ovf     <= div_ovf;
    end
  end

  md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (md_is_div),
    .opa    (a_mag),
    .opb    (b_mag),
    .done   (md_done),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  flags_t             mul_f, div_f, dz_f;

  always_comb begin
    prod = pend_neg ? -{md_hi, md_lo} : {md_hi, md_lo};
    quo  = pend_neg ? -md_lo : md_lo;
    rem  = pend_rem_neg ? -md_hi : md_hi;

    mul_f          = '0;
    mul_f.zero     = (prod == '0);
    mul_f.negative = pend_signed & prod[2*WIDTH-1];

    div_f          = '0;
    div_f.zero     = (quo == '0);
    div_f.negative = pend_signed & quo[WIDTH-1];
    div_f.overflow = pend_ovf;

    // Divide-by-zero result is all ones, so negative follows the signed/unsigned op.
    dz_f             = '0;
    dz_f.div_by_zero = 1'b1;
    dz_f.negative    = (aluc == MD_DIV);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && md_is_mul)                 state_nxt = MUL;
        else if (accept && md_is_div && !b_zero) state_nxt = DIV;
      end
      MUL, DIV: if (md_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    md_start = (state == IDLE) && (state_nxt != IDLE);
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      r_hi      <= '0;
      flg       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !md_en) begin
        out_valid <= 1'b1;
        r         <= alu_r;
        r_hi      <= '0;
        flg       <= alu_f;
      end else if (accept && !(md_is_mul || md_is_div)) begin
        out_valid <= 1'b1;
        r         <= '0;
        r_hi      <= '0;
        flg       <= '0;
      end else if (accept && md_is_div && b_zero) begin
        out_valid <= 1'b1;
        r         <= '1;
        r_hi      <= a;
        flg       <= dz_f;
      end else if (md_done) begin
        out_valid <= 1'b1;
        if (state == MUL) begin
          r    <= prod[WIDTH-1:0];
          r_hi <= prod[2*WIDTH-1:WIDTH];
          flg  <= mul_f;
        end else begin
          r    <= quo;
          r_hi <= rem;
          flg  <= div_f;
        end
      end
    end
  end

  assign zero        = flg.zero;
  assign carry       = flg.carry;
  assign negative    = flg.negative;
  assign overflow    = flg.overflow;
  assign div_by_zero = flg.div_by_zero;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu at WIDTH=32: expectations queued at issue, popped on out_valid.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, md_en, out_valid;
  logic [3:0]   aluc;
  logic [W-1:0] a, b, r, r_hi;
  logic         zero, carry, negative, overflow, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] r_hi;
    logic         zero;
    logic         carry;
    logic         negative;
    logic         overflow;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t exp_v, got_v;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .md_en(md_en),
    .aluc(aluc), .a(a), .b(b), .out_valid(out_valid), .r(r), .r_hi(r_hi),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic md, input logic [3:0] op,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  s;
    longint      p;
    logic [63:0] pu;
    int          sh;
    e  = '0;
    sh = int'(x[4:0]);
    if (!md) begin
      case (op)
        4'h0: begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.carry = s[W]; end
        4'h1: begin e.r = x - y; e.carry = (x < y); end
        4'h2: begin
          e.r = x + y;
          p = longint'($signed(x)) + longint'($signed(y));
          e.overflow = (p != longint'($signed(e.r)));
        end
        4'h3: begin
          e.r = x - y;
          p = longint'($signed(x)) - longint'($signed(y));
          e.overflow = (p != longint'($signed(e.r)));
        end
        4'h4: e.r = x & y;
        4'h5: e.r = x | y;
        4'h6: e.r = x ^ y;
        4'h7: e.r = ~(x | y);
        4'h8, 4'h9: e.r = {y[15:0], 16'h0000};
        4'hA: e.r = {31'b0, (x < y)};
        4'hB: e.r = {31'b0, ($signed(x) < $signed(y))};
        4'hC: begin e.r = $signed(y) >>> sh; e.carry = (sh != 0) ? y[sh-1] : 1'b0; end
        4'hD: begin e.r = y >> sh; e.carry = (sh != 0) ? y[sh-1] : 1'b0; end
        default: begin e.r = y << sh; e.carry = (sh != 0) ? y[32-sh] : 1'b0; end
      endcase
      if (op == 4'hA) begin
        e.zero = (x == y);
        e.carry = (x < y);
      end else if (op == 4'hB) begin
        e.zero = (x == y);
        e.negative = ($signed(x) < $signed(y));
      end else begin
        e.zero = (e.r == 0);
        e.negative = e.r[31];
      end
    end else begin
      case (op)
        4'h0: begin
          pu = {32'b0, x} * {32'b0, y};
          {e.r_hi, e.r} = pu;
          e.zero = (pu == 0);
        end
        4'h1: begin
          p = longint'($signed(x)) * longint'($signed(y));
          {e.r_hi, e.r} = p;
          e.zero = (p == 0);
          e.negative = (p < 0);
        end
        4'h2: begin
          if (y == 0) begin e.r = '1; e.r_hi = x; e.dbz = 1'b1; end
          else begin e.r = x / y; e.r_hi = x % y; e.zero = (e.r == 0); end
        end
        4'h3: begin
          if (y == 0) begin
            e.r = '1; e.r_hi = x; e.dbz = 1'b1; e.negative = 1'b1;
          end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.r = x; e.r_hi = '0; e.overflow = 1'b1; e.negative = 1'b1;
          end else begin
            e.r = $signed(x) / $signed(y);
            e.r_hi = $signed(x) % $signed(y);
            e.zero = (e.r == 0);
            e.negative = e.r[31];
          end
        end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  // Present one request at the current negedge; it is withdrawn just after the next posedge.
  task automatic drive(input logic m, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    md_en = m; aluc = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    int i;
    i = 0;
    lat = -1;
    while (lat < 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
      if (out_valid) lat = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; md_en = 1'b0; aluc = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
    checks++;
    if ({out_valid, got_v} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h out_valid=%b required=0", got_v, out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_addu();
    int lat;
    exp_v = '0; exp_v.zero = 1'b1; exp_v.carry = 1'b1;
    sb.push_back(exp_v);
    drive(1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_valid(4, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL addu_latency got=%0d required=1", lat); end
    got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL addu_result got=%h required=%h", got_v, exp_v); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL addu_pulse out_valid=%b required=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    md_en = 1'b0; aluc = 4'h2; a = 32'h7FFF_FFFF; b = 32'h1; in_valid = 1'b1;
    exp_v = '0; exp_v.r = 32'h8000_0000; exp_v.overflow = 1'b1; exp_v.negative = 1'b1;
    sb.push_back(exp_v);
    @(posedge clk);
    #1 aluc = 4'h3; a = 32'h8000_0000; b = 32'h1;
    exp_v = '0; exp_v.r = 32'h7FFF_FFFF; exp_v.overflow = 1'b1;
    sb.push_back(exp_v);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b[%0d] out_valid=%b got=%h required=%h", k, out_valid, got_v, exp_v);
      end
      if (k == 0) begin @(posedge clk); #1 in_valid = 1'b0; end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid=%b required=0", out_valid); end
  endtask

  task automatic test_shifts();
    logic [3:0]   ops [4] = '{4'hC, 4'hE, 4'hD, 4'hF};
    logic [W-1:0] xs  [4] = '{32'h4, 32'h0, 32'h20, 32'h1F};
    logic [W-1:0] ys  [4] = '{32'h8000_0018, 32'h1, 32'h8000_0005, 32'h3};
    logic [W-1:0] rs  [4] = '{32'hF800_0001, 32'h1, 32'h8000_0005, 32'h8000_0000};
    logic         cs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      exp_v = '0; exp_v.r = rs[i]; exp_v.carry = cs[i];
      exp_v.zero = (rs[i] == 0); exp_v.negative = rs[i][31];
      sb.push_back(exp_v);
      drive(1'b0, ops[i], xs[i], ys[i]);
      wait_valid(4, lat);
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 1 || got_v !== exp_v) begin
        errors++;
        $display("FAIL shift[%0d] lat=%0d got=%h required=%h", i, lat, got_v, exp_v);
      end
    end
  endtask

  task automatic test_alu_random();
    logic [W-1:0] x, y;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      x = $urandom; y = $urandom;
      if (i % 5 == 0) y = x;
      if (i % 7 == 0) x[4:0] = 5'd0;
      if (i % 11 == 3) begin x = 32'h8000_0000; y = 32'h7FFF_FFFF; end
      md_en = 1'b0; aluc = 4'(i % 16); a = x; b = y; in_valid = 1'b1;
      sb.push_back(model(1'b0, 4'(i % 16), x, y));
      @(posedge clk);
      @(negedge clk);
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got_v !== exp_v) begin
        errors++;
        $display("FAIL alu_rand[%0d] op=%h a=%h b=%h v=%b got=%h required=%h",
                 i, 4'(i % 16), x, y, out_valid, got_v, exp_v);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mult();
    int lat;
    int busy_bad;
    exp_v = '0; exp_v.r_hi = 32'hFFFF_FFFF; exp_v.r = 32'hFFFF_FFFA; exp_v.negative = 1'b1;
    sb.push_back(exp_v);
    drive(1'b1, 4'h1, 32'hFFFF_FFFE, 32'h3);
    lat = -1;
    busy_bad = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
      else if (in_ready !== 1'b0) busy_bad++;
      if (i == 5) begin in_valid = 1'b1; md_en = 1'b0; aluc = 4'h0; a = 32'h1; b = 32'h1; end
      if (i == 6) in_valid = 1'b0;
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mult_latency got=%0d required=33", lat); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL mult_busy ready_cycles=%0d required=0", busy_bad); end
    got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
    exp_v = sb.pop_front();
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL mult_result got=%h required=%h", got_v, exp_v); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mult_after out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_div();
    logic [3:0]   ops [3] = '{4'h3, 4'h2, 4'h3};
    logic [W-1:0] xs  [3] = '{32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
    logic [W-1:0] ys  [3] = '{32'h2, 32'h0, 32'hFFFF_FFFF};
    logic [W-1:0] rs  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] hs  [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    int           ls  [3] = '{33, 1, 33};
    int lat;
    for (int i = 0; i < 3; i++) begin
      exp_v = '0; exp_v.r = rs[i]; exp_v.r_hi = hs[i];
      exp_v.negative = (ops[i] == 4'h3);
      exp_v.dbz = (i == 1);
      exp_v.overflow = (i == 2);
      sb.push_back(exp_v);
      drive(1'b1, ops[i], xs[i], ys[i]);
      wait_valid(40, lat);
      checks++;
      if (lat !== ls[i]) begin errors++; $display("FAIL div_latency[%0d] got=%0d required=%0d", i, lat, ls[i]); end
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL div[%0d] got=%h required=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_md_random();
    logic [W-1:0] x, y;
    logic [3:0]   op;
    int lat;
    for (int i = 0; i < 16; i++) begin
      op = 4'(i % 4);
      x = $urandom; y = $urandom;
      if (i % 3 == 1) y = y >> 20;
      if (i % 8 == 6) y = '0;
      if (i == 9) x = '0;
      sb.push_back(model(1'b1, op, x, y));
      drive(1'b1, op, x, y);
      wait_valid(40, lat);
      checks++;
      if (lat !== ((op >= 4'h2 && y == 0) ? 1 : 33)) begin
        errors++;
        $display("FAIL md_rand_latency[%0d] op=%h got=%0d", i, op, lat);
      end
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL md_rand[%0d] op=%h a=%h b=%h got=%h required=%h", i, op, x, y, got_v, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    int lat;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      drive(1'b1, (i == 0) ? 4'h6 : 4'hF, 32'hDEAD_BEEF, 32'h0);
      wait_valid(4, lat);
      got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
      exp_v = sb.pop_front();
      checks++;
      if (lat !== 1 || got_v !== exp_v) begin
        errors++;
        $display("FAIL illegal[%0d] lat=%0d got=%h required=%h", i, lat, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    exp_v = '0; exp_v.r = 32'h2;
    sb.push_back(exp_v);
    drive(1'b0, 4'h0, 32'h1, 32'h1);
    wait_valid(4, lat);
    got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
    exp_v = sb.pop_front();
    checks++;
    if (lat !== 1 || got_v !== exp_v) begin errors++; $display("FAIL abort_pre got=%h required=%h", got_v, exp_v); end
    @(negedge clk);
    drive(1'b1, 4'h2, 32'hFFFF_FFFF, 32'h3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || r !== '0) begin
      errors++;
      $display("FAIL abort_ready in_ready=%b r=%h required 1/0", in_ready, r);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || r !== '0) begin
      errors++;
      $display("FAIL abort_quiet out_valid_pulses=%0d r=%h required 0/0", seen, r);
    end
    exp_v = '0; exp_v.r = 32'h5;
    sb.push_back(exp_v);
    drive(1'b0, 4'h0, 32'h2, 32'h3);
    wait_valid(4, lat);
    got_v = {r, r_hi, zero, carry, negative, overflow, div_by_zero};
    exp_v = sb.pop_front();
    checks++;
    if (lat !== 1 || got_v !== exp_v) begin errors++; $display("FAIL abort_recover got=%h required=%h", got_v, exp_v); end
  endtask

  initial begin
    test_reset();
    @(negedge clk); test_addu();
    @(negedge clk); test_back_to_back();
    @(negedge clk); test_shifts();
    test_alu_random();
    @(negedge clk); test_mult();
    @(negedge clk); test_div();
    @(negedge clk); test_md_random();
    @(negedge clk); test_illegal();
    @(negedge clk); test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
